// File: rtl/zero_sequencer.sv
// Multi-cycle instruction sequencer for the zero machine: fetches from an external
// registered code ROM, resolves operands against local memory and streams out values.
module zero_sequencer #(
   parameter int MemoryElementWidth = 12,
   parameter int NLocal             = 16,
   parameter int NOut               = 2,
   parameter int CodeSize           = 12,
   parameter int MaxSteps           = 1024
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                start,
   output logic [31:0]                         code_addr,
   input  logic [6+3*MemoryElementWidth-1:0]   code_data,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [MemoryElementWidth-1:0]       out_data,
   output logic [31:0]                         out_index,
   output logic [31:0]                         ip,
   output logic [31:0]                         steps,
   output logic                                finished,
   output logic                                error,
   output logic [1:0]                          error_code
);

   localparam int W  = MemoryElementWidth;
   localparam int IW = 6 + 3 * W;
   localparam int AW = (NLocal > 1) ? $clog2(NLocal) : 1;
   localparam logic [W:0] NLOCAL_LIM = (W+1)'(NLocal);

   localparam logic [3:0] OP_LABEL = 4'd0;
   localparam logic [3:0] OP_MOV   = 4'd1;
   localparam logic [3:0] OP_JEQ   = 4'd2;
   localparam logic [3:0] OP_JNE   = 4'd3;
   localparam logic [3:0] OP_JMP   = 4'd4;
   localparam logic [3:0] OP_OUT   = 4'd5;
   localparam logic [3:0] OP_HALT  = 4'd6;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_ILLEGAL = 2'd1;
   localparam logic [1:0] ERR_STEPS   = 2'd2;
   localparam logic [1:0] ERR_ADDR    = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_EXEC,
      S_OUT,
      S_DONE
   } state_t;

   state_t          state_reg;
   logic [IW-1:0]   instr_reg;
   logic [W-1:0]    mem_reg [NLocal];

   // Decoded fields of the latched instruction word
   logic [3:0]      op;
   logic            bimm;
   logic            cimm;
   logic [W-1:0]    fa;
   logic [W-1:0]    fb;
   logic [W-1:0]    fc;

   assign op   = instr_reg[3:0];
   assign bimm = instr_reg[4];
   assign cimm = instr_reg[5];
   assign fa   = instr_reg[6 +: W];
   assign fb   = instr_reg[6+W +: W];
   assign fc   = instr_reg[6+2*W +: W];

   logic            a_bad;
   logic            b_bad;
   logic            c_bad;
   logic            uses_b;
   logic            uses_c;
   logic            addr_err;
   logic            illegal;
   logic [W-1:0]    b_val;
   logic [W-1:0]    c_val;
   logic            mem_we;
   logic [31:0]     ip_inc;
   logic [31:0]     jump_target;
   logic [31:0]     out_index_inc;

   assign a_bad = ({1'b0, fa} >= NLOCAL_LIM);
   assign b_bad = ({1'b0, fb} >= NLOCAL_LIM);
   assign c_bad = ({1'b0, fc} >= NLOCAL_LIM);

   always_comb begin
      uses_b = 1'b0;
      uses_c = 1'b0;
      case (op)
         OP_MOV, OP_OUT:  uses_b = 1'b1;
         OP_JEQ, OP_JNE: begin
            uses_b = 1'b1;
            uses_c = 1'b1;
         end
         default: begin
            uses_b = 1'b0;
            uses_c = 1'b0;
         end
      endcase
   end

   // Only operands the opcode actually consumes can raise an address error
   assign addr_err = (uses_b && !bimm && b_bad) ||
                     (uses_c && !cimm && c_bad) ||
                     ((op == OP_MOV) && a_bad);
   assign illegal  = (op > OP_HALT);

   assign b_val = bimm ? fb : mem_reg[fb[AW-1:0]];
   assign c_val = cimm ? fc : mem_reg[fc[AW-1:0]];

   assign mem_we        = (state_reg == S_EXEC) && (op == OP_MOV) && !addr_err;
   assign ip_inc        = ip + 32'd1;
   assign jump_target   = 32'(fa);
   assign out_index_inc = (out_index == 32'(NOut - 1)) ? 32'd0 : out_index + 32'd1;
   assign code_addr     = ip;

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NLocal; i++) begin
            mem_reg[i] <= '0;
         end
      end else if (mem_we) begin
         mem_reg[fa[AW-1:0]] <= b_val;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg  <= S_IDLE;
         instr_reg  <= '0;
         ip         <= '0;
         steps      <= '0;
         out_index  <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         finished   <= 1'b0;
         error      <= 1'b0;
         error_code <= ERR_NONE;
      end else begin
         case (state_reg)
            S_IDLE, S_DONE: begin
               if (start) begin
                  ip         <= '0;
                  steps      <= '0;
                  out_index  <= '0;
                  finished   <= 1'b0;
                  error      <= 1'b0;
                  error_code <= ERR_NONE;
                  state_reg  <= S_FETCH;
               end
            end

            S_FETCH: begin
               if (ip >= 32'(CodeSize)) begin
                  finished  <= 1'b1;
                  state_reg <= S_DONE;
               end else if (steps == 32'(MaxSteps)) begin
                  finished   <= 1'b1;
                  error      <= 1'b1;
                  error_code <= ERR_STEPS;
                  state_reg  <= S_DONE;
               end else begin
                  state_reg <= S_LOAD;
               end
            end

            S_LOAD: begin
               instr_reg <= code_data;
               state_reg <= S_EXEC;
            end

            S_EXEC: begin
               if (illegal) begin
                  finished   <= 1'b1;
                  error      <= 1'b1;
                  error_code <= ERR_ILLEGAL;
                  state_reg  <= S_DONE;
               end else if (addr_err) begin
                  finished   <= 1'b1;
                  error      <= 1'b1;
                  error_code <= ERR_ADDR;
                  state_reg  <= S_DONE;
               end else begin
                  case (op)
                     OP_JEQ: begin
                        ip        <= (b_val == c_val) ? jump_target : ip_inc;
                        steps     <= steps + 32'd1;
                        state_reg <= S_FETCH;
                     end
                     OP_JNE: begin
                        ip        <= (b_val != c_val) ? jump_target : ip_inc;
                        steps     <= steps + 32'd1;
                        state_reg <= S_FETCH;
                     end
                     OP_JMP: begin
                        ip        <= jump_target;
                        steps     <= steps + 32'd1;
                        state_reg <= S_FETCH;
                     end
                     // out retires on the handshake, not here
                     OP_OUT: begin
                        out_data  <= b_val;
                        out_valid <= 1'b1;
                        state_reg <= S_OUT;
                     end
                     OP_HALT: begin
                        steps     <= steps + 32'd1;
                        finished  <= 1'b1;
                        state_reg <= S_DONE;
                     end
                     default: begin
                        ip        <= ip_inc;
                        steps     <= steps + 32'd1;
                        state_reg <= S_FETCH;
                     end
                  endcase
               end
            end

            S_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_index <= out_index_inc;
                  ip        <= ip_inc;
                  steps     <= steps + 32'd1;
                  state_reg <= S_FETCH;
               end
            end

            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule
